// File: rtl/pvt_chain_sweep_measure.sv
// Multi-channel PVT delay-chain monitor: launches a token into a selected
// DFF/NAND-buffer chain, counts cycles to a tap, and accumulates over several runs.

module pvt_delay_chain #(
  parameter int N = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_run,
  output logic [N-1:0] o_q
);
  // Each stage-to-stage path is two NAND gates wired as inverters; keep
  // attributes stop synthesis from collapsing them into a plain wire.
  (* keep = "true", dont_touch = "true" *) logic [N-2:0] w_nand1;
  (* keep = "true", dont_touch = "true" *) logic [N-2:0] w_nand2;
  logic [N-1:0] r_q;

  for (genvar i = 0; i < N - 1; i++) begin : g_buf
    assign w_nand1[i] = ~(r_q[i] & r_q[i]);
    assign w_nand2[i] = ~(w_nand1[i] & w_nand1[i]);
  end

  // Token enters at stage0 only on load; no recirculation from the last stage.
  always_ff @(posedge i_clk) begin
    if (i_rst || !(i_load || i_run)) r_q <= '0;
    else if (i_load)                 r_q <= N'(1);
    else                             r_q <= {w_nand2, 1'b0};
  end

  assign o_q = r_q;
endmodule

module pvt_chain_sweep_measure #(
  parameter int NCH       = 4,
  parameter int N         = 16,
  parameter int CNT_WIDTH = 8,
  parameter int RUN_WIDTH = 4,
  parameter int TIMEOUT   = 64,
  localparam int CH_W      = $clog2(NCH),
  localparam int TAP_W     = $clog2(N),
  localparam int ACC_WIDTH = CNT_WIDTH + RUN_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [CH_W-1:0]      i_ch_sel,
  input  logic [TAP_W-1:0]     i_tap,
  input  logic [RUN_WIDTH-1:0] i_n_runs,
  input  logic                 i_fi_kill,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_result_valid,
  output logic [ACC_WIDTH-1:0] o_acc_cnt,
  output logic [RUN_WIDTH-1:0] o_fail_cnt,
  output logic                 o_timeout
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_NEXT, S_DONE} state_t;

  state_t                 r_state, w_next;
  logic [CH_W-1:0]        r_ch;
  logic [TAP_W-1:0]       r_tap;
  logic [RUN_WIDTH-1:0]   r_nruns, r_run_idx, r_fail;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic                   r_to, r_rv;
  logic [NCH-1:0][N-1:0]  w_chain;
  logic [N-1:0]           w_sel;
  logic                   w_hit, w_bad_hit, w_lost, w_last;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    pvt_delay_chain #(.N(N)) u_chain (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (r_state == S_LOAD && r_ch == CH_W'(c)),
      .i_run  (r_state == S_RUN && r_ch == CH_W'(c) && !i_fi_kill),
      .o_q    (w_chain[c])
    );
  end

  assign w_sel     = w_chain[r_ch];
  assign w_hit     = w_sel[r_tap];
  assign w_bad_hit = (r_cnt != CNT_WIDTH'(r_tap)) || ($countones(w_sel) != 1);
  assign w_lost    = (w_sel == '0) || (r_cnt == CNT_WIDTH'(TIMEOUT - 1));
  assign w_last    = (r_run_idx == r_nruns - RUN_WIDTH'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_LOAD;
      S_LOAD: w_next = S_RUN;
      S_RUN:  if (w_hit || w_lost) w_next = S_NEXT;
      S_NEXT: w_next = w_last ? S_DONE : S_LOAD;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ch <= '0; r_tap <= '0; r_nruns <= '0; r_run_idx <= '0;
      r_cnt <= '0; r_acc <= '0; r_fail <= '0; r_to <= 1'b0; r_rv <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_ch      <= i_ch_sel;
          r_tap     <= (i_tap == '0) ? TAP_W'(1) : i_tap;
          r_nruns   <= (i_n_runs == '0) ? RUN_WIDTH'(1) : i_n_runs;
          r_run_idx <= '0;
          r_acc     <= '0;
          r_fail    <= '0;
          r_to      <= 1'b0;
          r_rv      <= 1'b0;
        end
        S_LOAD: r_cnt <= '0;
        S_RUN: begin
          // Tap hit wins over lost/timeout; counter freezes on exit so it stays <= TIMEOUT-1.
          if (w_hit) begin
            r_acc <= r_acc + ACC_WIDTH'(r_cnt);
            if (w_bad_hit) r_fail <= r_fail + RUN_WIDTH'(1);
          end else if (w_lost) begin
            r_fail <= r_fail + RUN_WIDTH'(1);
            r_to   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        S_NEXT: begin
          if (w_last) r_rv <= 1'b1;
          else        r_run_idx <= r_run_idx + RUN_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);
  assign o_result_valid = r_rv;
  assign o_acc_cnt      = r_acc;
  assign o_fail_cnt     = r_fail;
  assign o_timeout      = r_to;
endmodule
